// File: rtl/mandel_iter_ctrl_clocked.sv
// Mandelbrot iteration controller: feeds z back into the datapath, detects escape, counts iterations.
// Latency: accept at edge k -> out_valid after edge k+1+N*PIPE_LAT (N = mag2 samples); k+2 when max_iter==0.
// Backpressure: one pixel in flight; in_ready low outside IDLE, result held in DONE until out_ready.
// Optional: define ITER_STATS_EN to add the stat_pixels / stat_escaped handshake counters.
module mandel_iter_ctrl_clocked #(
    parameter int          PIPE_LAT   = 3,
    parameter logic [31:0] ESC_THRESH = 32'h4000_0000,
    parameter int          ITER_W     = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a0,
    input  logic [31:0]       in_b0,
    input  logic [ITER_W-1:0] max_iter,
    output logic              dp_ld,
    output logic              dp_flag_wait,
    output logic [31:0]       dp_a0,
    output logic [31:0]       dp_b0,
    output logic [31:0]       dp_z_re,
    output logic [31:0]       dp_z_im,
    input  logic [31:0]       z_re,
    input  logic [31:0]       z_im,
    input  logic [31:0]       mag2,
`ifdef ITER_STATS_EN
    output logic [31:0]       stat_pixels,
    output logic [31:0]       stat_escaped,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped
);

    localparam int TMR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(PIPE_LAT - 1);

    // ZERO is a single settle cycle used only by max_iter==0 pixels.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        ZERO = 3'd2,
        ITER = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        a0_q, a0_d, b0_q, b0_d;
    logic [31:0]        zr_q, zr_d, zi_q, zi_d;
    logic [ITER_W-1:0]  max_q, max_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ITER_W-1:0]  oiter_q, oiter_d;
    logic               oesc_q, oesc_d;
    logic               esc;

    // Overflowed squares (MSB set) escape; equality with the threshold does not.
    assign esc = mag2[31] || ($signed(mag2) > $signed(ESC_THRESH));

    // Next-state and datapath control decode.
    always_comb begin
        state_d      = state_q;
        a0_d         = a0_q;
        b0_d         = b0_q;
        zr_d         = zr_q;
        zi_d         = zi_q;
        max_d        = max_q;
        iter_d       = iter_q;
        timer_d      = timer_q;
        oiter_d      = oiter_q;
        oesc_d       = oesc_q;
        in_ready     = 1'b0;
        dp_ld        = 1'b0;
        dp_flag_wait = 1'b0;
        out_valid    = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready     = 1'b1;
                dp_flag_wait = 1'b1;
                if (in_valid) begin
                    a0_d    = in_a0;
                    b0_d    = in_b0;
                    max_d   = max_iter;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dp_ld   = 1'b1;
                zr_d    = 32'h0;
                zi_d    = 32'h0;
                iter_d  = '0;
                timer_d = TMR_RELOAD;
                if (max_q == '0) begin
                    oiter_d = '0;
                    oesc_d  = 1'b0;
                    state_d = ZERO;
                end else begin
                    state_d = ITER;
                end
            end
            ZERO: begin
                dp_flag_wait = 1'b1;
                state_d      = DONE;
            end
            ITER: begin
                if (timer_q == '0) begin
                    if (esc) begin
                        oiter_d = iter_q;
                        oesc_d  = 1'b1;
                        state_d = DONE;
                    end else if ((iter_q + ITER_W'(1)) == max_q) begin
                        oiter_d = max_q;
                        oesc_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        zr_d    = z_re;
                        zi_d    = z_im;
                        iter_d  = iter_q + ITER_W'(1);
                        timer_d = TMR_RELOAD;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DONE: begin
                out_valid    = 1'b1;
                dp_flag_wait = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            a0_q    <= '0;
            b0_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            max_q   <= '0;
            iter_q  <= '0;
            timer_q <= '0;
            oiter_q <= '0;
            oesc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a0_q    <= a0_d;
            b0_q    <= b0_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            max_q   <= max_d;
            iter_q  <= iter_d;
            timer_q <= timer_d;
            oiter_q <= oiter_d;
            oesc_q  <= oesc_d;
        end
    end

    assign dp_a0       = a0_q;
    assign dp_b0       = b0_q;
    assign dp_z_re     = zr_q;
    assign dp_z_im     = zi_q;
    assign out_iter    = oiter_q;
    assign out_escaped = oesc_q;

`ifdef ITER_STATS_EN
    logic [31:0] spix_q, sesc_q;

    // Result handshake counters; free-running wrap at 2^32.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            spix_q <= '0;
            sesc_q <= '0;
        end else if (state_q == DONE && out_ready) begin
            spix_q <= spix_q + 32'd1;
            if (oesc_q) begin
                sesc_q <= sesc_q + 32'd1;
            end
        end
    end

    assign stat_pixels  = spix_q;
    assign stat_escaped = sesc_q;
`endif

endmodule

// File: tb/tb_mandel_iter_ctrl_clocked.sv
// Bench for mandel_iter_ctrl_clocked: table of pixels plus reset / back-pressure sequences.
// The bench plays the datapath, presenting a chosen mag2 value for each sample window.
// Expected results are queued at accept and popped at the result handshake.
module tb_mandel_iter_ctrl_clocked;

    localparam int P = 3;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a0, in_b0;
    logic [15:0] max_iter;
    logic        dp_ld, dp_flag_wait;
    logic [31:0] dp_a0, dp_b0, dp_z_re, dp_z_im;
    logic [31:0] z_re, z_im, mag2;
    logic        out_valid, out_ready;
    logic [15:0] out_iter;
    logic        out_escaped;
`ifdef ITER_STATS_EN
    logic [31:0] stat_pixels, stat_escaped;
`endif

    mandel_iter_ctrl_clocked #(.PIPE_LAT(P), .ESC_THRESH(32'h4000_0000), .ITER_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a0(in_a0), .in_b0(in_b0), .max_iter(max_iter),
        .dp_ld(dp_ld), .dp_flag_wait(dp_flag_wait),
        .dp_a0(dp_a0), .dp_b0(dp_b0), .dp_z_re(dp_z_re), .dp_z_im(dp_z_im),
        .z_re(z_re), .z_im(z_im), .mag2(mag2),
`ifdef ITER_STATS_EN
        .stat_pixels(stat_pixels), .stat_escaped(stat_escaped),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_iter(out_iter), .out_escaped(out_escaped)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] a0, b0;
        logic [15:0] max_it;
        logic [31:0] m0, m1, m2, mn;
        logic [31:0] zre;
        int          hold;
        logic [15:0] exp_iter;
        logic        exp_esc;
        int          exp_lat;
        logic        chk_z;
    } vec_t;

    typedef struct {
        logic [15:0] iter;
        logic        esc;
        int          lat;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_pix = 0;
    int   exp_escn = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mag_at(input vec_t v, input int j);
        case (j)
            0:       return v.m0;
            1:       return v.m1;
            2:       return v.m2;
            default: return v.mn;
        endcase
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   lds;
        int   lat;
        bit   seen;
        chk("idle_in_ready", in_ready, 1'b1);
        in_a0    = v.a0;
        in_b0    = v.b0;
        max_iter = v.max_it;
        z_re     = v.zre;
        z_im     = v.zre ^ 32'h5A5A_0000;
        mag2     = mag_at(v, 0);
        in_valid = 1'b1;
        e.iter = v.exp_iter;
        e.esc  = v.exp_esc;
        e.lat  = v.exp_lat;
        sb.push_back(e);
        @(posedge aclk); #1;
        in_valid = 1'b0;
        lds = dp_ld ? 1 : 0;
        chk("load_dp_ld", dp_ld, 1'b1);
        chk("load_dp_a0", dp_a0, v.a0);
        chk("load_dp_b0", dp_b0, v.b0);
        chk("load_in_ready", in_ready, 1'b0);
        chk("load_flag_wait", dp_flag_wait, 1'b0);
        seen = 1'b0;
        lat  = 0;
        for (int t = 1; t <= 600 && !seen; t++) begin
            @(posedge aclk); #1;
            if (dp_ld) lds++;
            if (((t - 1) % P) == 0) mag2 = mag_at(v, (t - 1) / P);
            if (v.chk_z && t == 1 + P) begin
                chk("z_feedback_re", dp_z_re, v.zre);
                chk("z_feedback_im", dp_z_im, v.zre ^ 32'h5A5A_0000);
            end
            if (out_valid) begin
                seen = 1'b1;
                lat  = t;
            end
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL out_valid_timeout actual=none expected=lat%0d", v.exp_lat);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("dp_ld_pulses", lds, 1);
        chk("done_in_ready", in_ready, 1'b0);
        chk("done_flag_wait", dp_flag_wait, 1'b1);
        chk("out_iter", out_iter, e.iter);
        chk("out_escaped", out_escaped, e.esc);
        if (v.hold > 0) begin
            out_ready = 1'b0;
            for (int h = 0; h < v.hold; h++) begin
                @(posedge aclk); #1;
                chk("hold_out_valid", out_valid, 1'b1);
                chk("hold_out_iter", out_iter, e.iter);
                chk("hold_out_escaped", out_escaped, e.esc);
                chk("hold_in_ready", in_ready, 1'b0);
            end
            out_ready = 1'b1;
        end
        @(posedge aclk); #1;
        exp_pix++;
        if (e.esc) exp_escn++;
        chk("post_hs_out_valid", out_valid, 1'b0);
        chk("post_hs_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        //            a0            b0            max   m0            m1            m2            mn            zre           hold iter esc lat chk_z
        vecs[0] = '{32'h0,        32'h0,        16'd16,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 16'd16, 1'b0, 49, 1'b0};
        vecs[1] = '{32'hF800_0000, 32'h0200_0000, 16'd10, 32'h4000_0000, 32'h4000_0000, 32'h4000_0001, 32'h4000_0001, 32'h1000_0000, 5, 16'd2,  1'b1, 10, 1'b1};
        vecs[2] = '{32'h1234_5678, 32'h8765_4321, 16'd100, 32'h8000_0000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 16'd0,  1'b1, 4,  1'b0};
        vecs[3] = '{32'h0300_0000, 32'hFD00_0000, 16'd0,   32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 16'd0,  1'b0, 2,  1'b0};
        vecs[4] = '{32'h0100_0000, 32'h0000_0001, 16'd1,   32'h3FFF_FFFF, 32'h0,        32'h0,        32'h0,        32'h0,        0, 16'd1,  1'b0, 4,  1'b0};
        vecs[5] = '{32'hEEEE_0000, 32'h1111_0000, 16'd5,   32'h0000_0001, 32'h0000_0002, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_0000, 0, 16'd2,  1'b1, 10, 1'b1};
        vecs[6] = '{32'h0ABC_0000, 32'h0DEF_0000, 16'd3,   32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h0800_0000, 0, 16'd3,  1'b0, 10, 1'b1};

        // Reset held two cycles with a pending request.
        aresetn   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_a0     = 32'hDEAD_BEEF;
        in_b0     = 32'hCAFE_F00D;
        max_iter  = 16'd7;
        z_re      = 32'h0;
        z_im      = 32'h0;
        mag2      = 32'h0;
        repeat (2) @(posedge aclk);
        #1;
        in_valid = 1'b0;
        aresetn  = 1'b1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flag_wait", dp_flag_wait, 1'b1);
        chk("rst_dp_ld", dp_ld, 1'b0);
        chk("rst_dp_buses", {dp_a0, dp_b0} | {dp_z_re, dp_z_im}, 64'h0);
        chk("rst_out_iter", {out_escaped, out_iter}, 17'h0);
        @(posedge aclk); #1;
        chk("rst_no_accept_ld", dp_ld, 1'b0);
        chk("rst_no_accept_ready", in_ready, 1'b1);
        chk("rst_no_accept_a0", dp_a0, 32'h0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end
`ifdef ITER_STATS_EN
        chk("stat_pixels_table", stat_pixels, exp_pix);
        chk("stat_escaped_table", stat_escaped, exp_escn);
`endif

        // Reset while iterating abandons the pixel.
        in_a0    = 32'h0111_0000;
        in_b0    = 32'h0222_0000;
        max_iter = 16'd100;
        mag2     = 32'h0;
        z_re     = 32'h0333_0000;
        z_im     = 32'h0444_0000;
        in_valid = 1'b1;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        chk("mid_iter_busy", in_ready, 1'b0);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn  = 1'b1;
        exp_pix  = 0;
        exp_escn = 0;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_flag_wait", dp_flag_wait, 1'b1);
        chk("midrst_dp_z", {dp_z_re, dp_z_im}, 64'h0);
        chk("midrst_dp_a0", dp_a0, 32'h0);
        vcnt = 0;
        for (int t = 0; t < 60; t++) begin
            @(posedge aclk); #1;
            if (out_valid || dp_ld) vcnt++;
        end
        chk("midrst_no_result", vcnt, 0);

        // Three pixels after reset, one of them escaping.
        run_vec(vecs[4]);
        run_vec(vecs[2]);
        run_vec(vecs[3]);
`ifdef ITER_STATS_EN
        chk("stat_pixels", stat_pixels, 32'd3);
        chk("stat_escaped", stat_escaped, 32'd1);
`endif
        chk("stat_model_pixels", exp_pix, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
